instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program buffer plus fetch FSM (IDLE/RUN/DONE) that feeds a CPU Instruction port.
// Optional macro IFU_HALT_ON_SWI_EN: halt on SWI-class words (bits[27:24]=4'hF) instead of presenting them.
module instr_fetch_unit #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  output logic [31:0]   Instruction,
  output logic          instr_valid,
  output logic [31:0]   PC,
  output logic [AW:0]   prog_len,
  output logic          running,
  output logic          halted
);

  localparam logic [31:0] NOP = 32'hE1A00000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic [31:0] npc;
  logic        npc_end;
  logic        swi;
  logic        load_fire;
  logic        unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  assign running    = (state == S_RUN);
  assign halted     = (state == S_DONE);
  assign PC         = pc;
  assign load_ready = (state == S_IDLE) && (prog_len < (AW+1)'(DEPTH));
  assign load_fire  = load_valid && load_ready && !clear;

  assign word = mem[pc[AW+1:2]];

`ifdef IFU_HALT_ON_SWI_EN
  assign swi = running && (word[27:24] == 4'hF);
`else
  assign swi = 1'b0;
`endif

  assign Instruction = (running && !swi) ? word : NOP;
  assign instr_valid = running && !swi;

  assign npc     = branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
  assign npc_end = (npc[31:2] >= 30'(prog_len)) || (npc > 32'(DEPTH*4-4));

  // Buffer has no reset so a reset keeps the last program image.
  always_ff @(posedge clk) begin
    if (load_fire && !rst)
      mem[prog_len[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      prog_len <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (clear) begin
            prog_len <= '0;
            state    <= S_IDLE;
          end else begin
            if (load_fire)
              prog_len <= prog_len + 1'b1;
            if (start && (prog_len != '0)) begin
              pc    <= '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (swi)
            state <= S_DONE;
          else if (!stall) begin
            pc <= npc;
            if (npc_end)
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=64).
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC;
  logic [6:0]  prog_len;
  logic        running;
  logic        halted;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .clear(clear), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .Instruction(Instruction), .instr_valid(instr_valid), .PC(PC),
    .prog_len(prog_len), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_state got running=%b halted=%b exp 0 0", running, halted); end
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", PC); end
    checks++; if (prog_len !== 7'd0) begin errors++; $display("FAIL reset_prog_len got %0d exp 0", prog_len); end
    checks++; if (Instruction !== NOP || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr got %h/%b exp %h/0", Instruction, instr_valid, NOP); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load_word(32'hE5823000);
    load_word(32'hE5921000);
    load_word(32'hE0812003);
    checks++; if (prog_len !== 7'd3) begin errors++; $display("FAIL basic_prog_len got %0d exp 3", prog_len); end
    checks++; if (running !== 1'b0 || Instruction !== NOP) begin errors++; $display("FAIL basic_idle got running=%b instr=%h exp 0 %h", running, Instruction, NOP); end
    pulse_start();
    checks++; if (PC !== 32'd0 || Instruction !== 32'hE5823000 || instr_valid !== 1'b1) begin errors++; $display("FAIL basic_pc0 got %h %h %b exp 0 E5823000 1", PC, Instruction, instr_valid); end
    tick();
    checks++; if (PC !== 32'd4 || Instruction !== 32'hE5921000) begin errors++; $display("FAIL basic_pc4 got %h %h exp 4 E5921000", PC, Instruction); end
    tick();
    checks++; if (PC !== 32'd8 || Instruction !== 32'hE0812003) begin errors++; $display("FAIL basic_pc8 got %h %h exp 8 E0812003", PC, Instruction); end
    tick();
    checks++; if (halted !== 1'b1 || running !== 1'b0 || PC !== 32'd12) begin errors++; $display("FAIL basic_done got halted=%b running=%b pc=%h exp 1 0 c", halted, running, PC); end
    checks++; if (prog_len !== 7'd3 || instr_valid !== 1'b0 || Instruction !== NOP) begin errors++; $display("FAIL basic_done_out got len=%0d valid=%b instr=%h exp 3 0 %h", prog_len, instr_valid, Instruction, NOP); end
  endtask

  task automatic test_stall();
    pulse_start();
    checks++; if (PC !== 32'd0 || running !== 1'b1) begin errors++; $display("FAIL stall_restart got pc=%h running=%b exp 0 1", PC, running); end
    tick();
    stall = 1'b1;
    tick();
    checks++; if (PC !== 32'd4 || Instruction !== 32'hE5921000) begin errors++; $display("FAIL stall_hold1 got %h %h exp 4 E5921000", PC, Instruction); end
    tick();
    checks++; if (PC !== 32'd4 || Instruction !== 32'hE5921000) begin errors++; $display("FAIL stall_hold2 got %h %h exp 4 E5921000", PC, Instruction); end
    stall = 1'b0;
    tick();
    checks++; if (PC !== 32'd8 || Instruction !== 32'hE0812003) begin errors++; $display("FAIL stall_release got %h %h exp 8 E0812003", PC, Instruction); end
    tick();
    checks++; if (halted !== 1'b1 || PC !== 32'd12) begin errors++; $display("FAIL stall_done got halted=%b pc=%h exp 1 c", halted, PC); end
  endtask

  task automatic test_branch();
    pulse_start();
    tick();
    tick();
    checks++; if (PC !== 32'd8) begin errors++; $display("FAIL branch_setup got %h exp 8", PC); end
    branch_taken  = 1'b1;
    branch_target = 32'h1;
    stall = 1'b1;
    tick();
    checks++; if (PC !== 32'd8 || running !== 1'b1) begin errors++; $display("FAIL branch_stalled got pc=%h running=%b exp 8 1", PC, running); end
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    checks++; if (PC !== 32'd0 || Instruction !== 32'hE5823000) begin errors++; $display("FAIL branch_taken got %h %h exp 0 E5823000", PC, Instruction); end
    tick();
    tick();
    tick();
    checks++; if (halted !== 1'b1 || PC !== 32'd12) begin errors++; $display("FAIL branch_done got halted=%b pc=%h exp 1 c", halted, PC); end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    tick();
    tick();
    checks++; if (PC !== 32'd8 || running !== 1'b1) begin errors++; $display("FAIL midrst_setup got pc=%h running=%b exp 8 1", PC, running); end
    #1 rst = 1'b1;
    #1;
    checks++; if (running !== 1'b0 || halted !== 1'b0 || PC !== 32'd0) begin errors++; $display("FAIL midrst_state got running=%b halted=%b pc=%h exp 0 0 0", running, halted, PC); end
    checks++; if (Instruction !== NOP || instr_valid !== 1'b0 || prog_len !== 7'd0) begin errors++; $display("FAIL midrst_out got %h %b %0d exp %h 0 0", Instruction, instr_valid, prog_len, NOP); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) load_word(32'h10000000 + 32'(i));
    checks++; if (prog_len !== 7'd64 || load_ready !== 1'b0) begin errors++; $display("FAIL full_len got %0d ready=%b exp 64 0", prog_len, load_ready); end
    load_word(32'h2BADBEEF);
    checks++; if (prog_len !== 7'd64) begin errors++; $display("FAIL full_drop got %0d exp 64", prog_len); end
    pulse_start();
    checks++; if (Instruction !== 32'h10000000) begin errors++; $display("FAIL full_word0 got %h exp 10000000", Instruction); end
    for (int i = 0; i < 63; i++) tick();
    checks++; if (PC !== 32'd252 || Instruction !== 32'h1000003F) begin errors++; $display("FAIL full_last got %h %h exp fc 1000003f", PC, Instruction); end
    tick();
    checks++; if (halted !== 1'b1 || PC !== 32'd256) begin errors++; $display("FAIL full_done got halted=%b pc=%h exp 1 100", halted, PC); end
    pulse_clear();
    checks++; if (prog_len !== 7'd0 || load_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL full_clear got len=%0d ready=%b halted=%b exp 0 1 0", prog_len, load_ready, halted); end
    pulse_start();
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL empty_start got running=%b halted=%b exp 0 0", running, halted); end
  endtask

  task automatic test_swi();
    load_word(32'hE5823000);
    load_word(32'hEF000000);
    load_word(32'hE0812003);
    pulse_start();
    checks++; if (PC !== 32'd0 || Instruction !== 32'hE5823000) begin errors++; $display("FAIL swi_pc0 got %h %h exp 0 E5823000", PC, Instruction); end
    tick();
`ifdef IFU_HALT_ON_SWI_EN
    checks++; if (PC !== 32'd4 || Instruction !== NOP || instr_valid !== 1'b0) begin errors++; $display("FAIL swi_hide got %h %h %b exp 4 %h 0", PC, Instruction, instr_valid, NOP); end
    tick();
    checks++; if (halted !== 1'b1 || PC !== 32'd4) begin errors++; $display("FAIL swi_done got halted=%b pc=%h exp 1 4", halted, PC); end
`else
    checks++; if (PC !== 32'd4 || Instruction !== 32'hEF000000 || instr_valid !== 1'b1) begin errors++; $display("FAIL swi_present got %h %h %b exp 4 EF000000 1", PC, Instruction, instr_valid); end
    tick();
    tick();
    checks++; if (halted !== 1'b1 || PC !== 32'd12) begin errors++; $display("FAIL swi_done got halted=%b pc=%h exp 1 c", halted, PC); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_reset_midrun();
    test_full();
    do_reset();
    test_swi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
